// File: rtl/cpu_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter_if
// Signal bundle between the CPU core ports (fetch, data), the system bus and
// the cpu_bus_arbiter. Names keep the arbiter's point of view: i_* are inputs
// to the arbiter, o_* are driven by it.
//
//   fetch : i_fetch_request, i_fetch_address, o_fetch_rdata, o_fetch_ready
//   data  : i_data_request, i_data_rw, i_data_address, i_data_wdata,
//           o_data_rdata, o_data_ready
//   bus   : o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
//           i_bus_rdata, i_bus_ready
//   status: o_grant (00 idle, 01 fetch, 10 data), o_timeout
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment around it (core requesters + bus model)
// -----------------------------------------------------------------------------
interface cpu_bus_arbiter_if;

   // fetch requester
   logic        i_fetch_request;
   logic [31:0] i_fetch_address;
   logic [31:0] o_fetch_rdata;
   logic        o_fetch_ready;

   // data requester
   logic        i_data_request;
   logic        i_data_rw;
   logic [31:0] i_data_address;
   logic [31:0] i_data_wdata;
   logic [31:0] o_data_rdata;
   logic        o_data_ready;

   // system bus
   logic        o_bus_request;
   logic        o_bus_rw;
   logic [31:0] o_bus_address;
   logic [31:0] o_bus_wdata;
   logic [31:0] i_bus_rdata;
   logic        i_bus_ready;

   // status
   logic [1:0]  o_grant;
   logic        o_timeout;

   modport slave (
      input  i_fetch_request, i_fetch_address,
      output o_fetch_rdata, o_fetch_ready,
      input  i_data_request, i_data_rw, i_data_address, i_data_wdata,
      output o_data_rdata, o_data_ready,
      output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
      input  i_bus_rdata, i_bus_ready,
      output o_grant, o_timeout
   );

   modport master (
      output i_fetch_request, i_fetch_address,
      input  o_fetch_rdata, o_fetch_ready,
      output i_data_request, i_data_rw, i_data_address, i_data_wdata,
      input  o_data_rdata, o_data_ready,
      input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
      output i_bus_rdata, i_bus_ready,
      input  o_grant, o_timeout
   );

endinterface

// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
// Shares the single CPU memory bus between the instruction-fetch path and the
// data path. A grant is latched per transaction, the granted requester is
// muxed onto the bus, and read data / ready are routed back to that requester
// only. A watchdog aborts a granted transaction after TIMEOUT bus cycles.
//
// Parameters:
//   TIMEOUT - bus cycles allowed per granted transaction (0 = no watchdog)
//
// Ports:
//   i_clock - clock
//   i_reset - synchronous, active-high reset
//   bus     - cpu_bus_arbiter_if.slave (fetch, data, bus and status signals)
//
// Build option:
//   CPU_BUS_ARBITER_RR_EN - when defined, ties in IDLE go to the port that was
//   not granted last. When undefined, data always wins ties.
// -----------------------------------------------------------------------------
module cpu_bus_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic              i_clock,
   input  logic              i_reset,
   cpu_bus_arbiter_if.slave  bus
);

   // State encoding doubles as the o_grant status code.
   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      GRANT_FETCH = 2'b01,
      GRANT_DATA  = 2'b10
   } state_e;

   localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit              WD_EN    = (TIMEOUT != 0);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;

`ifdef CPU_BUS_ARBITER_RR_EN
   // 1 = data was the most recent grant, 0 = fetch (reset value).
   logic           last_data_q, last_data_d;
`endif

   // Combinational outputs
   logic        fetch_ready, data_ready;
   logic [31:0] fetch_rdata, data_rdata;
   logic        bus_request, bus_rw;
   logic [31:0] bus_address, bus_wdata;
   logic        timeout;
   logic        pick_data;
   logic        wd_expire;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
`ifdef CPU_BUS_ARBITER_RR_EN
         last_data_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
`ifdef CPU_BUS_ARBITER_RR_EN
         last_data_q <= last_data_d;
`endif
      end
   end

   // --------------------------------------------------------------------------
   // Tie-break: which port wins when leaving IDLE
   // --------------------------------------------------------------------------
`ifdef CPU_BUS_ARBITER_RR_EN
   // On a tie, data wins only if fetch was granted last.
   assign pick_data = bus.i_data_request & (~bus.i_fetch_request | ~last_data_q);
`else
   assign pick_data = bus.i_data_request;
`endif

   // Abort fires on the TIMEOUT-th granted cycle; bus ready in that same
   // cycle is checked first and wins.
   assign wd_expire = WD_EN && (cnt_q == CNT_LAST);

   // --------------------------------------------------------------------------
   // Next state and outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
`ifdef CPU_BUS_ARBITER_RR_EN
      last_data_d = last_data_q;
`endif
      fetch_ready = 1'b0;
      fetch_rdata = '0;
      data_ready  = 1'b0;
      data_rdata  = '0;
      bus_request = 1'b0;
      bus_rw      = 1'b0;
      bus_address = '0;
      bus_wdata   = '0;
      timeout     = 1'b0;

      case (state_q)
         IDLE: begin
            // Counter restarts for every grant; i_bus_ready is ignored here.
            cnt_d = '0;
            if (pick_data) begin
               state_d     = GRANT_DATA;
`ifdef CPU_BUS_ARBITER_RR_EN
               last_data_d = 1'b1;
`endif
            end else if (bus.i_fetch_request) begin
               state_d     = GRANT_FETCH;
`ifdef CPU_BUS_ARBITER_RR_EN
               last_data_d = 1'b0;
`endif
            end
         end

         GRANT_FETCH: begin
            // Request follows the requester; the grant itself is held.
            bus_request = bus.i_fetch_request;
            bus_address = bus.i_fetch_address;
            if (bus.i_bus_ready) begin
               fetch_ready = 1'b1;
               fetch_rdata = bus.i_bus_rdata;
               state_d     = IDLE;
            end else if (wd_expire) begin
               fetch_ready = 1'b1;
               timeout     = 1'b1;
               state_d     = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         GRANT_DATA: begin
            bus_request = bus.i_data_request;
            bus_rw      = bus.i_data_rw;
            bus_address = bus.i_data_address;
            bus_wdata   = bus.i_data_wdata;
            if (bus.i_bus_ready) begin
               data_ready = 1'b1;
               data_rdata = bus.i_bus_rdata;
               state_d    = IDLE;
            end else if (wd_expire) begin
               data_ready = 1'b1;
               timeout    = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Output wiring
   // --------------------------------------------------------------------------
   assign bus.o_fetch_ready = fetch_ready;
   assign bus.o_fetch_rdata = fetch_rdata;
   assign bus.o_data_ready  = data_ready;
   assign bus.o_data_rdata  = data_rdata;
   assign bus.o_bus_request = bus_request;
   assign bus.o_bus_rw      = bus_rw;
   assign bus.o_bus_address = bus_address;
   assign bus.o_bus_wdata   = bus_wdata;
   assign bus.o_grant       = state_q;
   assign bus.o_timeout     = timeout;

endmodule
